mux_sel_sequencer: RTL

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

---
 rtl/mux_sel_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_sel_sequencer.sv
// Round-robin N:1 mux select sequencer with registered select and valid/ready handshake.
// Optional hold timeout is compiled in with `define MUXSEL_TIMEOUT_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no live grant; sel holds its last value, sel_valid low
//   S_GRANT | sel/grant frozen until a handshake (or hold timeout)
module mux_sel_sequencer #(
    parameter int N   = 9,
    parameter int M   = 4,
    parameter int TMO = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [M-1:0] sel,
    output logic         sel_valid,
    input  logic         sel_ready,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         timeout
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t       r_state, w_state_nxt;
    logic [M-1:0] r_sel, w_sel_nxt;
    logic [M-1:0] r_ptr, w_ptr_nxt;
    logic         r_valid, w_valid_nxt;
    logic [N-1:0] r_grant, w_grant_nxt;
    logic         r_busy;
    logic         w_hs, w_tmo_hit, w_release, w_found;
    logic [M-1:0] w_sel_inc, w_base, w_win;
    logic [M:0]   w_idx;

    // Illegal parameter sets leave this block empty; it exists so the ranges are stated in one place.
    if (N < 2 || N > (1 << M) || N <= (1 << (M - 1)) || TMO < 1 || TMO > 255) begin : g_bad_params
    end

    assign w_hs      = r_valid & sel_ready;
    assign w_release = (r_state == S_GRANT) & (w_hs | w_tmo_hit);
    assign w_sel_inc = (r_sel == M'(N - 1)) ? '0 : r_sel + 1'b1;
    // A releasing grant searches from the pointer it is about to write, so back-to-back grants stay fair.
    assign w_base    = w_release ? w_sel_inc : r_ptr;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, w_base} + (M + 1)'(k);
            if (w_idx >= (M + 1)'(N)) w_idx = w_idx - (M + 1)'(N);
            if (!w_found && req[w_idx[M-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[M-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_sel_inc;
                    if (w_found) begin
                        w_sel_nxt = w_win;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_grant_nxt = w_valid_nxt ? ({{(N - 1){1'b0}}, 1'b1} << w_sel_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef MUXSEL_TIMEOUT_EN
    logic [7:0] r_hold;
    logic       r_timeout;

    // Counter restarts on every release so a back-to-back grant gets a fresh hold window.
    assign w_tmo_hit = (r_state == S_GRANT) & ~w_hs & (r_hold == 8'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != S_GRANT || w_release) r_hold <= '0;
            else                                 r_hold <= r_hold + 8'd1;
            r_timeout <= w_tmo_hit;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign sel       = r_sel;
    assign sel_valid = r_valid;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule
